result_mem_reader: RTL and testbench
====================================

# result_mem_reader

Drains the 8-entry, 9-bit sum memory written by the pairwise-add stage and presents each stored sum on a valid/ready stream, while accumulating a running total and maximum over the pass. It sits directly downstream of the adder stage. It drives the read-only port of the result block RAM, which has a synchronous read latency of `READ_LAT` cycles. The stream output feeds display/ILA logic; `total`/`max_val` give a one-shot summary per pass.

## Interface
- `DEPTH`, 8: number of memory entries read per pass (power of two).
- `ADDR_W`, 3: address width, log2(`DEPTH`).
- `DATA_W`, 9: width of each stored sum.
- `READ_LAT`, 1: block RAM read latency in cycles (legal 1..4).
- `SUM_W`, `DATA_W`+`ADDR_W` (12): width of `total`; cannot overflow.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a pass; honoured only in IDLE.
- `mem_ena` out 1: RAM port enable; high only in ISSUE.
- `mem_wea` out 1: RAM write enable; constant 0.
- `mem_addr` out `ADDR_W`: RAM read address.
- `mem_dout` in `DATA_W`: RAM read data, valid `READ_LAT` cycles after ISSUE.
- `out_valid` out 1: `out_data` holds a sum.
- `out_ready` in 1: consumer accepts when high with `out_valid`.
- `out_data` out `DATA_W`: current sum.
- `out_index` out `ADDR_W`: address `out_data` came from.
- `out_last` out 1: high with `out_valid` for index `DEPTH`-1.
- `total` out `SUM_W`: sum of all accepted elements this pass.
- `max_val` out `DATA_W`: maximum accepted element this pass.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a pass completes.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE: `start`=1 clears `total`, `max_val`, and the index register to 0, then goes to ISSUE.
- ISSUE (1 cycle): `mem_ena`=1, `mem_addr`=index. Loads the wait counter with `READ_LAT`-1, then goes to WAIT.
- WAIT: decrements the counter. When the counter is 0, registers `mem_dout` into `out_data` and index into `out_index`, then goes to PRESENT. With `READ_LAT`=1, WAIT lasts exactly one cycle.
- PRESENT: `out_valid`=1. `out_data`, `out_index`, and `out_last` are held stable until the handshake.
- On handshake (`out_valid` & `out_ready`):
  - `total` += `out_data`, zero-extended.
  - `max_val` = max(`max_val`, `out_data`), unsigned.
  - If index = `DEPTH`-1, go to FINISH; otherwise index+1 and go to ISSUE.
- FINISH (1 cycle): `done`=1, then IDLE. `total`/`max_val` hold until the next accepted `start`.
- `start` outside IDLE is ignored and not queued.
- Index never wraps within a pass; it is reset to 0 only by `start` or `reset`.
- `mem_addr` holds its last value when `mem_ena`=0.

## Timing
- Reset values: state IDLE; every output 0 (`mem_ena`, `mem_wea`, `mem_addr`, `out_valid`, `out_data`, `out_index`, `out_last`, `total`, `max_val`, `busy`, `done`).
- `reset` overrides all activity the same cycle, including mid-pass and simultaneous `start`. There is no partial-pass completion and no `done` pulse.
- `start` sampled at edge N:
  - ISSUE during N+1.
  - `out_valid` first high during N+2+`READ_LAT`.
- Per element, with `out_ready` held high: 2+`READ_LAT` cycles. A full pass at defaults takes 24 cycles from first ISSUE to FINISH.
- Back-pressure has no limit. No RAM access occurs while `out_valid`=1.
- `total`/`max_val` update on the edge after the handshake.
- `done` is high during the cycle after the last handshake; `busy` falls the following cycle.

## Test plan
- RAM preloaded {0x003,0x1FF,0x010,0x100,0x000,0x0FE,0x1FE,0x021}, `out_ready`=1, `start` pulse:
  - 8 beats in address order with indices 0..7; `out_last` only on index 7.
  - `total`=0x62F, `max_val`=0x1FF.
  - `done` exactly once, 24 cycles after first ISSUE.
- All entries 0x1FF → `total`=0xFF8 (no overflow), `max_val`=0x1FF.
- Back-pressure: `out_ready` low for 5 cycles on index 3 → `out_data`/`out_index` stable, `mem_ena`=0 throughout, `total` unchanged until the accepting edge.
- `reset` asserted while presenting index 4 → next cycle all outputs 0 and IDLE, no `done`. A following `start` restarts at address 0.
- `start` pulsed while `busy` → ignored; exactly one pass and one `done`. A second `start` after `done` clears `total` before re-accumulating.
- `READ_LAT`=3 build, same data as the first scenario → identical beats and `total`, 4 cycles between each ISSUE and its `out_valid`.

Source files
------------

// File: rtl/result_mem_reader.sv
// result_mem_reader
//   Drains a DEPTH-entry sum memory through its read-only block RAM port.
//   Each stored sum is presented on a valid/ready stream. A running total and
//   a maximum are accumulated over the pass.
//
// Ports
//   clk, reset         : single clock; synchronous active-high reset
//   start              : begin a pass (honoured only when idle)
//   mem_ena/wea/addr   : RAM port (read-only, so wea is tied low)
//   mem_dout           : RAM read data, READ_LAT cycles after the enable
//   out_valid/ready    : stream handshake
//   out_data/index/last: current sum, its address, final-element flag
//   total, max_val     : sum and maximum of the accepted elements this pass
//   busy, done         : not-idle flag; one-cycle end-of-pass pulse
module result_mem_reader #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 9,
  parameter int READ_LAT = 1,
  parameter int SUM_W    = DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [SUM_W-1:0]  total,
  output logic [DATA_W-1:0] max_val,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = 3;  // holds READ_LAT-1 for READ_LAT up to 4

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_FINISH
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_index;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_index;
  logic [SUM_W-1:0]    r_total;
  logic [DATA_W-1:0]   r_max;
  logic                w_hs;
  logic                w_last_idx;

  assign w_hs       = (r_state == S_PRESENT) && out_ready;
  assign w_last_idx = (r_index == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (r_cnt == '0) w_next = S_PRESENT;
      S_PRESENT: if (w_hs) w_next = w_last_idx ? S_FINISH : S_ISSUE;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index     <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_total     <= '0;
      r_max       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_index <= '0;
          r_total <= '0;
          r_max   <= '0;
        end
        S_ISSUE: r_cnt <= CNT_W'(READ_LAT - 1);
        S_WAIT: begin
          // Counter reaches zero in the cycle the RAM data is valid.
          if (r_cnt == '0) begin
            r_out_data  <= mem_dout;
            r_out_index <= r_index;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PRESENT: if (out_ready) begin
          r_total <= r_total + SUM_W'(r_out_data);
          if (r_out_data > r_max) r_max <= r_out_data;
          // Index stays at DEPTH-1 after the last element; no wrap.
          if (!w_last_idx) r_index <= r_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address follows the index, which only moves on a handshake, so it
  // naturally holds its value while the port is disabled.
  assign mem_ena   = (r_state == S_ISSUE);
  assign mem_wea   = 1'b0;
  assign mem_addr  = r_index;
  assign out_valid = (r_state == S_PRESENT);
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = out_valid && (r_out_index == ADDR_W'(DEPTH - 1));
  assign total     = r_total;
  assign max_val   = r_max;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_result_mem_reader.sv
// Directed bench for result_mem_reader: a READ_LAT=1 instance and a
// READ_LAT=3 instance, each fed by a behavioural block RAM model.
module tb_result_mem_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // READ_LAT = 1 instance
  logic        start1 = 1'b0, rdy1 = 1'b0;
  logic        ena1, wea1, ov1, ol1, busy1, done1;
  logic [2:0]  addr1, oi1;
  logic [8:0]  dout1, od1, mx1;
  logic [11:0] tot1;

  // READ_LAT = 3 instance
  logic        start3 = 1'b0, rdy3 = 1'b0;
  logic        ena3, wea3, ov3, ol3, busy3, done3;
  logic [2:0]  addr3, oi3;
  logic [8:0]  dout3, od3, mx3;
  logic [11:0] tot3;

  result_mem_reader #(.READ_LAT(1)) u1 (
    .clk(clk), .reset(rst), .start(start1),
    .mem_ena(ena1), .mem_wea(wea1), .mem_addr(addr1), .mem_dout(dout1),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .out_index(oi1),
    .out_last(ol1), .total(tot1), .max_val(mx1), .busy(busy1), .done(done1)
  );

  result_mem_reader #(.READ_LAT(3)) u3 (
    .clk(clk), .reset(rst), .start(start3),
    .mem_ena(ena3), .mem_wea(wea3), .mem_addr(addr3), .mem_dout(dout3),
    .out_valid(ov3), .out_ready(rdy3), .out_data(od3), .out_index(oi3),
    .out_last(ol3), .total(tot3), .max_val(mx3), .busy(busy3), .done(done3)
  );

  // RAM models: registered read, extra output stages for longer latency.
  logic [8:0] ram1 [8];
  logic [8:0] ram3 [8];
  logic [8:0] p0 = '0, p1 = '0, p2 = '0, q0 = '0;
  always @(posedge clk) begin
    if (ena1) q0 <= ram1[addr1];
    if (ena3) p0 <= ram3[addr3];
    p1 <= p0;
    p2 <= p1;
  end
  assign dout1 = q0;
  assign dout3 = p2;

  // Observation on the falling edge: beats, issue cycles, done pulses.
  int cyc = 0;
  int done_cnt1 = 0, done_cyc1 = 0, done_cnt3 = 0, done_cyc3 = 0;
  logic [8:0] bd1[$], bd3[$];
  logic [2:0] bi1[$], bi3[$];
  logic       bl1[$], bl3[$];
  int         iss1[$], iss3[$], vrise3[$];
  logic       ov3_d = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (ov1 && rdy1) begin bd1.push_back(od1); bi1.push_back(oi1); bl1.push_back(ol1); end
    if (ov3 && rdy3) begin bd3.push_back(od3); bi3.push_back(oi3); bl3.push_back(ol3); end
    if (ena1) iss1.push_back(cyc);
    if (ena3) iss3.push_back(cyc);
    if (ov3 && !ov3_d) vrise3.push_back(cyc);
    ov3_d = ov3;
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    if (done3) begin done_cnt3++; done_cyc3 = cyc; end
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done1(input string tag, input int maxc);
    int n = 0;
    while (done1 !== 1'b1 && n < maxc) begin step(); n++; end
    chk(tag, {31'd0, done1}, 32'd1);
  endtask

  task automatic clear1();
    bd1.delete(); bi1.delete(); bl1.delete(); iss1.delete();
  endtask

  logic [8:0] A [8];

  task automatic check_beats1(input string tag, input logic [8:0] exp [8]);
    chk({tag, "_nbeats"}, bd1.size(), 8);
    for (int i = 0; i < 8 && i < bd1.size(); i++) begin
      chk({tag, "_data"},  bd1[i], exp[i]);
      chk({tag, "_index"}, bi1[i], i);
      chk({tag, "_last"},  bl1[i], (i == 7) ? 1 : 0);
    end
  endtask

  initial begin
    int base, n;
    A = '{9'h003, 9'h1FF, 9'h010, 9'h100, 9'h000, 9'h0FE, 9'h1FE, 9'h021};
    for (int i = 0; i < 8; i++) begin ram1[i] = A[i]; ram3[i] = A[i]; end

    // ---- reset state
    step(); step();
    chk("rst_ena",   ena1, 0);  chk("rst_wea",   wea1, 0);
    chk("rst_addr",  addr1, 0); chk("rst_valid", ov1, 0);
    chk("rst_data",  od1, 0);   chk("rst_index", oi1, 0);
    chk("rst_last",  ol1, 0);   chk("rst_total", tot1, 0);
    chk("rst_max",   mx1, 0);   chk("rst_busy",  busy1, 0);
    chk("rst_done",  done1, 0);
    rst = 1'b0;
    step();

    // ---- basic pass, ready held high
    clear1();
    base = done_cnt1;
    rdy1 = 1'b1; start1 = 1'b1; step(); start1 = 1'b0;
    chk("s1_issue_ena", ena1, 1);
    chk("s1_issue_addr", addr1, 0);
    chk("s1_busy", busy1, 1);
    step();
    chk("s1_wait_valid", ov1, 0);
    step();
    chk("s1_first_valid", ov1, 1);
    wait_done1("s1_done_seen", 60);
    chk("s1_total", tot1, 12'h62F);
    chk("s1_max", mx1, 9'h1FF);
    chk("s1_busy_at_done", busy1, 1);
    step();
    chk("s1_done_pulse", done1, 0);
    chk("s1_busy_after", busy1, 0);
    chk("s1_done_count", done_cnt1 - base, 1);
    chk("s1_pass_cycles", done_cyc1 - iss1[0], 24);
    chk("s1_hold_total", tot1, 12'h62F);
    check_beats1("s1", A);

    // ---- all-max data: total must not overflow
    for (int i = 0; i < 8; i++) ram1[i] = 9'h1FF;
    clear1();
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_done1("s2_done_seen", 60);
    chk("s2_total", tot1, 12'hFF8);
    chk("s2_max", mx1, 9'h1FF);
    step();

    // ---- back-pressure on index 3
    for (int i = 0; i < 8; i++) ram1[i] = A[i];
    rdy1 = 1'b0;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (ov1 !== 1'b1 && n < 20) begin step(); n++; end
      chk("bp_valid_seen", ov1, 1);
      if (i == 3) begin
        for (int k = 0; k < 4; k++) begin
          step();
          chk("bp_valid_hold", ov1, 1);
          chk("bp_data_hold", od1, 9'h100);
          chk("bp_index_hold", oi1, 3);
          chk("bp_ena_low", ena1, 0);
          chk("bp_total_hold", tot1, 12'h212);
        end
      end
      rdy1 = 1'b1; step(); rdy1 = 1'b0;
      if (i == 3) chk("bp_total_after", tot1, 12'h312);
    end
    wait_done1("bp_done_seen", 10);
    chk("bp_total", tot1, 12'h62F);
    step();

    // ---- reset while presenting index 4
    base = done_cnt1;
    rdy1 = 1'b1;
    start1 = 1'b1; step(); start1 = 1'b0;
    n = 0;
    while (!(ov1 === 1'b1 && oi1 === 3'd4) && n < 40) begin step(); n++; end
    chk("rm_reach_idx4", {29'd0, oi1}, 4);
    rst = 1'b1; start1 = 1'b1; step(); rst = 1'b0; start1 = 1'b0;
    chk("rm_valid", ov1, 0);  chk("rm_data", od1, 0);
    chk("rm_index", oi1, 0);  chk("rm_addr", addr1, 0);
    chk("rm_total", tot1, 0); chk("rm_max", mx1, 0);
    chk("rm_busy", busy1, 0); chk("rm_done", done1, 0);
    chk("rm_ena", ena1, 0);
    step(); step();
    chk("rm_still_idle", busy1, 0);
    chk("rm_no_done", done_cnt1 - base, 0);
    clear1();
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("rm_restart_ena", ena1, 1);
    chk("rm_restart_addr", addr1, 0);
    wait_done1("rm_done_seen", 60);
    chk("rm_total_after", tot1, 12'h62F);
    step();
    check_beats1("rm", A);

    // ---- start while busy is ignored; restart clears the total
    base = done_cnt1;
    clear1();
    start1 = 1'b1; step(); start1 = 1'b0;
    step(); step(); step();
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_done1("sb_done_seen", 60);
    for (int k = 0; k < 30; k++) step();
    chk("sb_done_count", done_cnt1 - base, 1);
    chk("sb_beats", bd1.size(), 8);
    chk("sb_busy_idle", busy1, 0);
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("sb_total_cleared", tot1, 0);
    chk("sb_max_cleared", mx1, 0);
    wait_done1("sb2_done_seen", 60);
    chk("sb2_total", tot1, 12'h62F);
    step();

    // ---- READ_LAT = 3 instance
    rdy3 = 1'b1;
    start3 = 1'b1; step(); start3 = 1'b0;
    n = 0;
    while (done3 !== 1'b1 && n < 80) begin step(); n++; end
    chk("l3_done_seen", done3, 1);
    chk("l3_total", tot3, 12'h62F);
    chk("l3_max", mx3, 9'h1FF);
    step();
    chk("l3_done_count", done_cnt3, 1);
    chk("l3_pass_cycles", done_cyc3 - iss3[0], 40);
    chk("l3_nbeats", bd3.size(), 8);
    for (int i = 0; i < 8 && i < bd3.size(); i++) begin
      chk("l3_data", bd3[i], A[i]);
      chk("l3_index", bi3[i], i);
      chk("l3_last", bl3[i], (i == 7) ? 1 : 0);
    end
    chk("l3_nissue", iss3.size(), 8);
    for (int i = 0; i < 8 && i < iss3.size() && i < vrise3.size(); i++)
      chk("l3_issue_to_valid", vrise3[i] - iss3[i], 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
